sensor_buffer_ctrl: RTL and testbench

//  Record/playback sequencer for the sensor path, sharing the single dmem port with the processor.

---
 rtl/sensor_ctrl_pkg.sv | 14 +
 rtl/sample_tick_gen.sv | 28 ++
 rtl/sensor_buffer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sensor_buffer_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_ctrl_pkg.sv
// Shared types and widths for the sensor record/playback sequencer.
package sensor_ctrl_pkg;

    localparam int DMEM_AW = 12;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        REC,
        PLAY_RD,
        PLAY_DATA
    } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every SAMPLE_DIV clocks, synchronous restart to phase 0.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST) && !restart;

endmodule

// File: rtl/sensor_buffer_ctrl.sv
// Record/playback sequencer sharing the dmem port with the processor (processor has priority).
// Optional: define SENSOR_OVERRUN_CNT_EN to add the overrun_count output.
module sensor_buffer_ctrl
    import sensor_ctrl_pkg::*;
#(
    parameter logic [DMEM_AW-1:0] BASE_ADDR  = 12'd1024,
    parameter int                 DEPTH      = 256,
    parameter int                 SAMPLE_DIV = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic [DMEM_AW-1:0]      cpu_address_dmem,
    input  logic [DATA_W-1:0]       cpu_data,
    input  logic                    cpu_wren,
    output logic [DMEM_AW-1:0]      address_dmem,
    output logic [DATA_W-1:0]       data,
    output logic                    wren,
    input  logic [DATA_W-1:0]       q_dmem,
    input  logic [DATA_W-1:0]       sensor_input_to_save,
    input  logic [DATA_W-1:0]       save_signal,
    input  logic [DATA_W-1:0]       load_signal,
    output logic [DATA_W-1:0]       sensor_output,
    output logic                    sensor_valid,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  rec_count
`ifdef SENSOR_OVERRUN_CNT_EN
    ,
    output logic [15:0]             overrun_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t              state;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       remaining;
    logic [DATA_W-1:0]   wr_sample;
    logic                wr_pending;
    logic                rd_pending;
    logic                save_d;
    logic                load_d;
    logic                save_rise;
    logic                load_rise;
    logic                tick;
    logic                wr_issue;
    logic                rd_issue;
    logic                unused_ctrl_bits;

    assign save_rise = save_signal[0] & ~save_d;
    assign load_rise = load_signal[0] & ~load_d;
    assign unused_ctrl_bits = ^{save_signal[31:1], load_signal[31:1]};

    assign wr_issue = (state == REC) && wr_pending && !cpu_req;
    assign rd_issue = (state == PLAY_RD) && rd_pending && !cpu_req;
    assign busy     = (state != IDLE);

    // Holding the divider at phase 0 in IDLE aligns the first tick SAMPLE_DIV cycles after entry.
    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (state == IDLE),
        .tick    (tick)
    );

    always_comb begin
        address_dmem = cpu_address_dmem;
        data         = cpu_data;
        wren         = 1'b0;
        if (cpu_req) begin
            wren = cpu_wren;
        end else if (wr_issue) begin
            address_dmem = BASE_ADDR + DMEM_AW'(wr_ptr);
            data         = wr_sample;
            wren         = 1'b1;
        end else if (rd_issue) begin
            address_dmem = BASE_ADDR + DMEM_AW'(rd_ptr);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sensor_output <= '0;
            sensor_valid  <= 1'b0;
            rec_count     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            remaining     <= '0;
            wr_sample     <= '0;
            wr_pending    <= 1'b0;
            rd_pending    <= 1'b0;
            save_d        <= 1'b0;
            load_d        <= 1'b0;
`ifdef SENSOR_OVERRUN_CNT_EN
            overrun_count <= '0;
`endif
        end else begin
            save_d       <= save_signal[0];
            load_d       <= load_signal[0];
            sensor_valid <= 1'b0;
            case (state)
                IDLE: begin
                    wr_pending <= 1'b0;
                    rd_pending <= 1'b0;
                    if (save_rise) begin
                        state     <= REC;
                        rec_count <= '0;
                        wr_ptr    <= '0;
`ifdef SENSOR_OVERRUN_CNT_EN
                        overrun_count <= '0;
`endif
                    end else if (load_rise && rec_count != '0) begin
                        // Once the buffer has wrapped, wr_ptr points at the oldest sample.
                        state      <= PLAY_RD;
                        rd_ptr     <= (rec_count == FULL) ? wr_ptr : '0;
                        remaining  <= rec_count;
                        rd_pending <= 1'b1;
                    end
                end
                REC: begin
                    if (wr_issue) begin
                        wr_ptr <= wr_ptr + PW'(1);
                        if (rec_count != FULL) begin
                            rec_count <= rec_count + CW'(1);
                        end
                    end
                    // A tick landing on a still-blocked write replaces that sample.
                    if (save_signal[0]) begin
                        if (tick) begin
                            wr_sample  <= sensor_input_to_save;
                            wr_pending <= 1'b1;
`ifdef SENSOR_OVERRUN_CNT_EN
                            if (wr_pending && !wr_issue && overrun_count != 16'hFFFF) begin
                                overrun_count <= overrun_count + 16'd1;
                            end
`endif
                        end else if (wr_issue) begin
                            wr_pending <= 1'b0;
                        end
                    end else if (wr_issue || !wr_pending) begin
                        wr_pending <= 1'b0;
                        state      <= IDLE;
                    end
                end
                PLAY_RD: begin
                    if (tick) begin
                        rd_pending <= 1'b1;
                    end else if (rd_issue) begin
                        rd_pending <= 1'b0;
                    end
                    if (rd_issue) begin
                        state <= PLAY_DATA;
                    end
                end
                PLAY_DATA: begin
                    if (tick) begin
                        rd_pending <= 1'b1;
                    end
                    sensor_output <= q_dmem;
                    sensor_valid  <= 1'b1;
                    rd_ptr        <= rd_ptr + PW'(1);
                    remaining     <= remaining - CW'(1);
                    state         <= (remaining == CW'(1)) ? IDLE : PLAY_RD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_buffer_ctrl.sv
// Directed bench for sensor_buffer_ctrl (DEPTH=4, SAMPLE_DIV=4); checks overrun_count when SENSOR_OVERRUN_CNT_EN is defined.
module tb_sensor_buffer_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [11:0] cpu_address_dmem;
    logic [31:0] cpu_data;
    logic        cpu_wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [31:0] sensor_input_to_save;
    logic [31:0] save_signal;
    logic [31:0] load_signal;
    logic [31:0] sensor_output;
    logic        sensor_valid;
    logic        busy;
    logic [2:0]  rec_count;
`ifdef SENSOR_OVERRUN_CNT_EN
    logic [15:0] overrun_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle        = 0;

    logic [31:0] mem [4096];
    logic [11:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] val_q [$];
    int          val_cyc_q [$];
    logic        val_busy_q [$];
    logic [31:0] exp_play [4];

    typedef struct {
        logic        req;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_data;
        logic        check_ad;
    } mux_vec_t;

    mux_vec_t vecs [5];

    sensor_buffer_ctrl #(
        .BASE_ADDR  (12'd1024),
        .DEPTH      (4),
        .SAMPLE_DIV (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .cpu_req              (cpu_req),
        .cpu_address_dmem     (cpu_address_dmem),
        .cpu_data             (cpu_data),
        .cpu_wren             (cpu_wren),
        .address_dmem         (address_dmem),
        .data                 (data),
        .wren                 (wren),
        .q_dmem               (q_dmem),
        .sensor_input_to_save (sensor_input_to_save),
        .save_signal          (save_signal),
        .load_signal          (load_signal),
        .sensor_output        (sensor_output),
        .sensor_valid         (sensor_valid),
        .busy                 (busy),
        .rec_count            (rec_count)
`ifdef SENSOR_OVERRUN_CNT_EN
        ,
        .overrun_count        (overrun_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Synchronous dmem: read data appears the cycle after the address cycle.
    always @(posedge clock) begin
        if (wren) mem[address_dmem] <= data;
        q_dmem <= mem[address_dmem];
    end

    always @(posedge clock) begin
        if (reset && wren) begin
            wr_addr_q.push_back(address_dmem);
            wr_data_q.push_back(data);
        end
    end

    always @(negedge clock) begin
        if (sensor_valid) begin
            val_q.push_back(sensor_output);
            val_cyc_q.push_back(cycle);
            val_busy_q.push_back(busy);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input mux_vec_t v);
        @(negedge clock);
        cpu_req          = v.req;
        cpu_address_dmem = v.addr;
        cpu_data         = v.wdata;
        cpu_wren         = v.we;
        #1;
        checkOutput("mux wren", 32'(wren), 32'(v.exp_we));
        if (v.check_ad) begin
            checkOutput("mux address", 32'(address_dmem), 32'(v.exp_addr));
            checkOutput("mux data", data, v.exp_data);
        end
    endtask

    task automatic recordSamples(input int n, input logic [31:0] first);
        @(negedge clock);
        save_signal = 32'h1;
        @(negedge clock);
        sensor_input_to_save = first;
        for (int i = 1; i < n; i++) begin
            repeat (4) @(negedge clock);
            sensor_input_to_save = first + 32'(i);
        end
        repeat (4) @(negedge clock);
        save_signal = 32'h0;
        sensor_input_to_save = 32'hBAD0_0000;
    endtask

    task automatic playBack(input int n);
        int base;
        int load_cyc;
        int waited;
        base = val_q.size();
        @(negedge clock);
        load_signal = 32'hFFFF_FFFF;
        load_cyc = cycle;
        @(negedge clock);
        load_signal = 32'h0;
        waited = 0;
        while (val_q.size() < base + n && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("play valid count", 32'(val_q.size() - base), 32'(n));
        if (val_q.size() >= base + n) begin
            checkOutput("play latency", 32'(val_cyc_q[base] - load_cyc), 32'd3);
            for (int i = 0; i < n; i++) begin
                checkOutput($sformatf("play sample %0d", i), val_q[base + i], exp_play[i]);
                if (i > 0) checkOutput($sformatf("play spacing %0d", i), 32'(val_cyc_q[base + i] - val_cyc_q[base + i - 1]), 32'd4);
            end
            checkOutput("busy at last valid", 32'(val_busy_q[base + n - 1]), 32'd0);
        end
    endtask

    initial begin
        int wb;
        int vb;
        logic busy_seen;

        vecs[0] = '{1'b1, 12'h010, 32'h1111_0000, 1'b1, 1'b1, 12'h010, 32'h1111_0000, 1'b1};
        vecs[1] = '{1'b1, 12'hFFF, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'hFFF, 32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{1'b0, 12'h123, 32'h5555_5555, 1'b1, 1'b0, 12'h000, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 12'h7A5, 32'hCAFE_F00D, 1'b1, 1'b1, 12'h7A5, 32'hCAFE_F00D, 1'b1};

        reset = 1'b0;
        cpu_req = 1'b0;
        cpu_address_dmem = '0;
        cpu_data = '0;
        cpu_wren = 1'b0;
        sensor_input_to_save = '0;
        save_signal = '0;
        load_signal = '0;

        repeat (3) @(negedge clock);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset rec_count", 32'(rec_count), 32'd0);
        checkOutput("reset sensor_output", sensor_output, 32'd0);
        checkOutput("reset sensor_valid", 32'(sensor_valid), 32'd0);
        checkOutput("reset wren", 32'(wren), 32'd0);
        reset = 1'b1;

        $display("[TB] mux vectors in IDLE");
        foreach (vecs[i]) applyStimulus(vecs[i]);
        @(negedge clock);
        cpu_req = 1'b0;
        cpu_wren = 1'b0;

        $display("[TB] record 5,6,7");
        wb = wr_addr_q.size();
        recordSamples(3, 32'd5);
        @(negedge clock);
        checkOutput("rec3 busy after", 32'(busy), 32'd0);
        checkOutput("rec3 rec_count", 32'(rec_count), 32'd3);
        checkOutput("rec3 write count", 32'(wr_addr_q.size() - wb), 32'd3);
        if (wr_addr_q.size() >= wb + 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("rec3 addr %0d", i), 32'(wr_addr_q[wb + i]), 32'd1024 + 32'(i));
                checkOutput($sformatf("rec3 data %0d", i), wr_data_q[wb + i], 32'd5 + 32'(i));
            end
        end

        $display("[TB] playback of 3");
        exp_play[0] = 32'd5; exp_play[1] = 32'd6; exp_play[2] = 32'd7; exp_play[3] = 32'd0;
        playBack(3);

        $display("[TB] wrap record 1..6");
        wb = wr_addr_q.size();
        recordSamples(6, 32'd1);
        @(negedge clock);
        checkOutput("wrap rec_count", 32'(rec_count), 32'd4);
        checkOutput("wrap write count", 32'(wr_addr_q.size() - wb), 32'd6);
        if (wr_addr_q.size() >= wb + 6) begin
            checkOutput("wrap 5th addr", 32'(wr_addr_q[wb + 4]), 32'd1024);
            checkOutput("wrap 6th addr", 32'(wr_addr_q[wb + 5]), 32'd1025);
        end
        exp_play[0] = 32'd3; exp_play[1] = 32'd4; exp_play[2] = 32'd5; exp_play[3] = 32'd6;
        playBack(4);

        $display("[TB] contention");
        wb = wr_addr_q.size();
        fork
            recordSamples(3, 32'd10);
            begin
                @(negedge clock);
                repeat (4) @(negedge clock);
                cpu_req = 1'b1;
                cpu_address_dmem = 12'h055;
                cpu_data = 32'hAAAA;
                cpu_wren = 1'b1;
                repeat (2) @(negedge clock);
                cpu_req = 1'b0;
                cpu_wren = 1'b0;
                repeat (2) @(negedge clock);
                cpu_req = 1'b1;
                repeat (5) @(negedge clock);
                cpu_req = 1'b0;
            end
        join
        @(negedge clock);
        checkOutput("cont write count", 32'(wr_addr_q.size() - wb), 32'd4);
        if (wr_addr_q.size() >= wb + 4) begin
            checkOutput("cont cpu addr 0", 32'(wr_addr_q[wb]), 32'h055);
            checkOutput("cont cpu data 1", wr_data_q[wb + 1], 32'hAAAA);
            checkOutput("cont engine addr", 32'(wr_addr_q[wb + 2]), 32'd1024);
            checkOutput("cont engine data", wr_data_q[wb + 2], 32'd10);
            checkOutput("cont drop addr", 32'(wr_addr_q[wb + 3]), 32'd1025);
            checkOutput("cont drop data", wr_data_q[wb + 3], 32'd12);
        end
        checkOutput("cont rec_count", 32'(rec_count), 32'd2);
`ifdef SENSOR_OVERRUN_CNT_EN
        checkOutput("cont overrun_count", 32'(overrun_count), 32'd1);
`endif

        $display("[TB] save and load together, then empty load");
        vb = val_q.size();
        @(negedge clock);
        save_signal = 32'h1;
        load_signal = 32'h1;
        @(negedge clock);
        checkOutput("both edges busy", 32'(busy), 32'd1);
        checkOutput("both edges rec_count", 32'(rec_count), 32'd0);
        save_signal = 32'h0;
        load_signal = 32'h0;
        repeat (2) @(negedge clock);
        checkOutput("both edges back idle", 32'(busy), 32'd0);
        load_signal = 32'h1;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            load_signal = 32'h0;
            busy_seen = busy_seen | busy;
        end
        checkOutput("empty load valid count", 32'(val_q.size() - vb), 32'd0);
        checkOutput("empty load busy", 32'(busy_seen), 32'd0);

        $display("[TB] reset mid-record");
        @(negedge clock);
        save_signal = 32'h1;
        @(negedge clock);
        sensor_input_to_save = 32'd21;
        repeat (8) @(negedge clock);
        checkOutput("pre-reset wren", 32'(wren), 32'd1);
        checkOutput("pre-reset address", 32'(address_dmem), 32'd1025);
        checkOutput("pre-reset rec_count", 32'(rec_count), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset rec_count", 32'(rec_count), 32'd0);
        checkOutput("mid reset wren", 32'(wren), 32'd0);
        checkOutput("mid reset sensor_output", sensor_output, 32'd0);
        repeat (2) @(negedge clock);
        save_signal = 32'h0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("post reset busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
